// File: rtl/destruct_stream_if.sv
// destruct_stream_if: stream bundle for destruct_stream.
//   Input side : ivalid, iready, idata[ISIZE], ilast  (wide words from the read FIFO)
//   Output side: ovalid, oready, odata[OSIZE], olast, omask[OSIZE/8]
// master = the environment (drives input words, consumes output words)
// slave  = the converter
interface destruct_stream_if #(
  parameter int ISIZE = 256,
  parameter int OSIZE = 24
);
  logic               ivalid;
  logic               iready;
  logic [ISIZE-1:0]   idata;
  logic               ilast;
  logic               ovalid;
  logic               oready;
  logic [OSIZE-1:0]   odata;
  logic               olast;
  logic [OSIZE/8-1:0] omask;

  modport master (
    output ivalid, idata, ilast, oready,
    input  iready, ovalid, odata, olast, omask
  );

  modport slave (
    input  ivalid, idata, ilast, oready,
    output iready, ovalid, odata, olast, omask
  );
endinterface

// File: rtl/destruct_stream.sv
// destruct_stream: wide-to-narrow stream width converter (VDMA read path).
// Takes ISIZE-bit words and emits OSIZE-bit words through a bit-level residue
// buffer. On ilast the residue is flushed as a zero-padded partial word with
// a byte mask and olast.
// Ports:
//   clock    - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   sync_clr - synchronous clear of buffer, flush flag and output register
//   bus      - destruct_stream_if.slave (input and output handshakes)
// Build option: DESTRUCT_STREAM_LSB_FIRST_EN selects LSB-first bit order
// (default MSB-first).
module destruct_stream #(
  parameter int ISIZE = 256,
  parameter int OSIZE = 24
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              sync_clr,
  destruct_stream_if.slave  bus
);
  localparam int CAP = ISIZE + OSIZE - 1;
  localparam int LW  = $clog2(CAP + 1);
  localparam int MB  = OSIZE / 8;
  localparam logic [LW-1:0] OS_L = LW'(OSIZE);
  localparam logic [LW-1:0] IS_L = LW'(ISIZE);

  // Residue bits beyond the level are kept zero, so a partial word falls out
  // already zero-padded when sliced the same way as a full word.
  logic [CAP-1:0]   rbuf;
  logic [LW-1:0]    lvl;
  logic             flush;
  logic             ovalid_q, olast_q;
  logic [OSIZE-1:0] odata_q;
  logic [MB-1:0]    omask_q;

  logic             accept, free, ld_full, ld_part, last_full;
  logic [CAP-1:0]   ins, rbuf_sh;
  logic [OSIZE-1:0] head;
  logic [LW-1:0]    nbytes;
  logic [MB-1:0]    pmask;

  // rst_n gating keeps iready low while reset is held.
  assign bus.iready = rst_n && !sync_clr && !flush && (lvl < OS_L);
  assign bus.ovalid = ovalid_q;
  assign bus.olast  = olast_q;
  assign bus.odata  = odata_q;
  assign bus.omask  = omask_q;

  assign accept    = bus.ivalid && bus.iready;
  assign free      = !ovalid_q || bus.oready;
  assign ld_full   = free && (lvl >= OS_L);
  assign ld_part   = free && flush && (lvl != '0) && (lvl < OS_L);
  assign last_full = flush && (lvl == OS_L);
  assign nbytes    = (lvl + LW'(7)) >> 3;

`ifdef DESTRUCT_STREAM_LSB_FIRST_EN
  // Valid residue occupies rbuf[lvl-1:0]; new bits go above it.
  assign ins     = {{(OSIZE-1){1'b0}}, bus.idata} << lvl;
  assign head    = rbuf[OSIZE-1:0];
  assign rbuf_sh = rbuf >> OSIZE;
  assign pmask   = ~({MB{1'b1}} << nbytes);
`else
  // Valid residue occupies the top lvl bits of rbuf; new bits go below it.
  assign ins     = {bus.idata, {(OSIZE-1){1'b0}}} >> lvl;
  assign head    = rbuf[CAP-1 -: OSIZE];
  assign rbuf_sh = rbuf << OSIZE;
  assign pmask   = ~({MB{1'b1}} >> nbytes);
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rbuf     <= '0;
      lvl      <= '0;
      flush    <= 1'b0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      odata_q  <= '0;
      omask_q  <= '0;
    end else if (sync_clr) begin
      rbuf     <= '0;
      lvl      <= '0;
      flush    <= 1'b0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      odata_q  <= '0;
      omask_q  <= '0;
    end else begin
      // Residue buffer: accept and load are mutually exclusive by construction.
      if (accept) begin
        rbuf <= rbuf | ins;
        lvl  <= lvl + IS_L;
        if (bus.ilast) flush <= 1'b1;
      end else if (ld_full) begin
        rbuf <= rbuf_sh;
        lvl  <= lvl - OS_L;
        if (last_full) flush <= 1'b0;
      end else if (ld_part) begin
        rbuf  <= '0;
        lvl   <= '0;
        flush <= 1'b0;
      end

      // Output register.
      if (ld_full) begin
        ovalid_q <= 1'b1;
        odata_q  <= head;
        omask_q  <= '1;
        olast_q  <= last_full;
      end else if (ld_part) begin
        ovalid_q <= 1'b1;
        odata_q  <= head;
        omask_q  <= pmask;
        olast_q  <= 1'b1;
      end else if (free) begin
        ovalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/destruct_stream.md
# destruct_stream

Wide-to-narrow stream width converter for the VDMA read path. It takes ISIZE-bit words from the read-data FIFO and emits a continuous OSIZE-bit pixel stream. Any ISIZE/OSIZE ratio is supported through a bit-level residue buffer, with valid/ready handshakes on both sides. At frame end (`ilast`) it flushes the residue as a final, zero-padded partial word with a byte mask.

## Interface
- ISIZE, 256, input word width in bits; multiple of 8; ISIZE >= OSIZE
- OSIZE, 24, output word width in bits; multiple of 8
- clock  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- sync_clr  in  1  synchronous clear: drop buffer, flush flag and output register (line/frame realign)
- ivalid  in  1  input word valid
- iready  out  1  input word accepted when ivalid&&iready
- idata  in  ISIZE  input word
- ilast  in  1  last input word of frame; qualified by ivalid&&iready
- ovalid  out  1  output word valid
- oready  in  1  downstream accepts when ovalid&&oready
- odata  out  OSIZE  output word
- olast  out  1  last output word of frame
- omask  out  OSIZE/8  byte valid mask; bit OSIZE/8-1 = most-significant byte

## Operation
- Residue buffer: CAP = ISIZE+OSIZE-1 bits. Level counter L has width $clog2(CAP+1). Flag `flush`.
- Bit order is MSB-first: the first output word is idata[ISIZE-1 -: OSIZE]. New input bits are appended below the existing residue.
- iready = (L < OSIZE) && !flush && !sync_clr. This is combinational from registers only and never depends on ivalid.
- On accept: L <= L+ISIZE. If ilast, flush <= 1.
- The output register is free when !ovalid || oready.
- Load rule, evaluated each cycle when the output register is free:
  - L >= OSIZE: load the top OSIZE bits; L <= L-OSIZE; omask all ones. If flush && L==OSIZE, set olast=1 and clear flush.
  - flush && 0 < L < OSIZE: load the residue left-justified and zero-padded; omask top ceil(L/8) bits set, rest 0; olast=1; L <= 0; flush <= 0.
  - Otherwise, when free: ovalid <= 0.
- Accept and load never occur in the same cycle, because accept requires L<OSIZE and !flush.
- sync_clr has priority over all other updates: L, flush, ovalid and olast <= 0. Any held output word is discarded.
- Reset values: ovalid=0, olast=0, odata=0, omask=0, iready=0 during reset, L=0, flush=0.

## Timing
- Input accepted at edge N produces ovalid=1 after edge N+1, so first-word latency is 1 cycle.
- Steady state with oready=1: one output word per cycle, plus one bubble cycle per input word (the accept cycle).
- For the default 256/24 configuration: 10 or 11 outputs per input word.
- odata, olast and omask are held stable while ovalid && !oready.
- iready rises the cycle after the load that drops L below OSIZE.
- During flush, iready stays low until the final olast word is loaded. The next frame's word can be accepted in the following cycle.
- Reset asserted mid-frame clears everything immediately and asynchronously. sync_clr takes effect at the next edge.

## Configuration
- DESTRUCT_STREAM_LSB_FIRST_EN defined: bit order is LSB-first.
  - The first output word is idata[OSIZE-1:0].
  - New bits are appended above the residue.
  - Partial words are right-justified; omask has its low ceil(L/8) bits set.
- Not defined: MSB-first as described in Operation.

## Test plan
- Single frame, ISIZE=256/OSIZE=24: one word with ilast, oready=1 -> 10 full words (omask=3'b111), then 1 partial word (top 16 bits valid, omask=3'b110, olast=1). Bit sequence matches idata MSB-first.
- Exact fit: 3 words (768 bits), ilast on the third -> 32 words, olast only on word 32 with omask=3'b111, and no partial word.
- Backpressure: random oready (50%) over 8 input words -> no word lost or duplicated; odata/olast/omask stable while stalled; iready never high while L>=24.
- sync_clr mid-frame after 4 output words -> ovalid=0 next cycle, iready=1 next cycle. The next frame's first output equals its idata[255:232].
- Async reset mid-flush -> all outputs 0 immediately. After release, a new single-word frame produces 11 outputs as in scenario 1.
- DESTRUCT_STREAM_LSB_FIRST_EN build: repeat scenario 1 -> the first word is idata[23:0]; the partial word is idata[255:240] right-justified with omask=3'b011.
